digdug_hvgen: RTL and testbench
===============================

# digdug_hvgen

Video timing generator and pixel output stage for the Dig Dug core. It divides MCLK (48 MHz) down to a 6 MHz pixel enable and produces the PH/PV raster counters that drive `fpga_digdug`. It consumes the 8-bit palette pixel POUT that `fpga_digdug` returns and emits a sync-aligned, blank-gated 24-bit RGB stream with HSYNC/VSYNC/HBLANK/VBLANK/DE for the framework video path.

## Interface
Parameters:
- H_TOTAL, 384: pixel clocks per line.
- H_VIS, 288: visible pixels per line (PH 0..287).
- HS_START, 304: nominal HSYNC start column, before H_ADJ.
- HS_WIDTH, 32: HSYNC width in pixels.
- V_TOTAL, 264: lines per frame.
- V_VIS, 224: visible lines (PV 0..223).
- VS_START, 240: VSYNC start line.
- VS_WIDTH, 8: VSYNC width in lines.
- PIX_LAT, 2: POUT latency after PH/PV, in pixel clocks. Range 1..7.

Ports:
- MCLK  in  1  master clock, 48.0 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- H_ADJ  in  4  signed horizontal sync shift, -8..+7 pixels.
- POUT  in  8  palette pixel from core: [2:0] R, [5:3] G, [7:6] B.
- CE_PIX  out  1  one-MCLK pixel enable, every 8th cycle.
- PH  out  9  horizontal counter to core.
- PV  out  9  vertical counter to core.
- R, G, B  out  8 each  expanded colour, black when blanked.
- HSYNC, VSYNC  out  1  active-high sync, aligned with RGB.
- HBLANK, VBLANK, DE  out  1  aligned with RGB; DE = !HBLANK & !VBLANK.

## Operation
- Divider: 3-bit counter DIV increments every MCLK. CE_PIX = (DIV == 7), registered.
- Raster: on CE_PIX, PH increments. At PH == H_TOTAL-1, PH wraps to 0 and PV increments. At PV == V_TOTAL-1 with PH wrap, PV wraps to 0. No other state changes PH/PV.
- H_ADJ capture: sampled into ADJ_Q only on the CE_PIX where PH and PV both wrap to 0. Mid-frame changes have no effect until the next frame. Reset value of ADJ_Q is 0.
- Raw raster flags, computed from the current PH/PV:
  - hb = PH >= H_VIS
  - vb = PV >= V_VIS
  - hs = PH in [HS_START+ADJ_Q, HS_START+ADJ_Q+HS_WIDTH), using 10-bit signed arithmetic. Parameters guarantee no wrap.
  - vs = PV in [VS_START, VS_START+VS_WIDTH)
- Alignment: a PIX_LAT-deep shift register of {hb, vb, hs, vs} advances on CE_PIX. The output stage uses the tap PIX_LAT stages back, which is the same stage at which POUT is valid for that PH/PV.
- Colour expansion, on CE_PIX, registered:
  - R = {r,r,r[2:1]}
  - G = {g,g,g[2:1]}
  - B = {b,b,b,b}
  - When the delayed hb or vb is set, R/G/B = 0.
- HSYNC/VSYNC/HBLANK/VBLANK/DE are registered on the same CE_PIX as RGB.

## Timing
- Reset: every output is 0 while RESET_N is low, and every counter, shift stage and ADJ_Q is 0. Reset asserted mid-line clears immediately (asynchronous). After release, the first CE_PIX is on the 8th MCLK edge (DIV 0→7).
- Frame period: H_TOTAL×V_TOTAL×8 MCLK = 811008 cycles, ≈59.19 Hz.
- Latency: a POUT sampled on CE_PIX n appears on RGB after the CE_PIX n edge. Sync and blank flags for PH=k appear PIX_LAT+1 pixel clocks after PH=k.
- Outputs change only on MCLK edges where CE_PIX is high. PH/PV hold steady for 8 MCLK.
- Simultaneous PH and PV wrap: ADJ_Q updates and PV = 0 take effect on the same edge.

## Structure
- Shared package `digdug_pkg`: the default timing constants (H_TOTAL, H_VIS, V_TOTAL, V_VIS, sync positions) and the POUT bitfield positions, so that the video module uses the same values.
- One sub-module, `digdug_rgb_expand`: registered 3/3/2→8/8/8 expansion with blank gating.
- Counters, divider and delay line stay in the top of this block.

## Test plan
- Reset release: RESET_N low for 5 cycles, then high → all outputs 0, first CE_PIX 8 MCLK later, PH=1 after it.
- Line/frame wrap:
  - PH 383 → 0 and PV increments.
  - PH 383 with PV 263 → both 0.
  - VSYNC high for exactly 8 lines starting PV=240.
  - Frame is 811008 MCLK.
- H_ADJ:
  - Set −8 mid-frame → HSYNC unchanged that frame; next frame it starts at PH=296 (+PIX_LAT+1 delay).
  - Set +7 → starts at 311.
- Colour: POUT=8'hFF at visible PH=10 → RGB FF/FF/FF. POUT=8'h01 → R=8'h24, G=0, B=0.
- Blanking: POUT=8'hFF driven constantly → RGB 0 and DE 0 for PH 288..383 and PV 224..263, with edges exactly PIX_LAT+1 pixels after the raw boundary.
- Reset mid-line at PH=150 → outputs clear on the next MCLK sample without waiting for CE_PIX. Restart from PH=0, PV=0.

Source files
------------

// File: rtl/digdug_pkg.sv
// Shared Dig Dug video constants: default raster timing, POUT colour field
// positions and the 3/2-bit to 8-bit colour expansion helpers.
package digdug_pkg;

    localparam int DEF_H_TOTAL  = 384;
    localparam int DEF_H_VIS    = 288;
    localparam int DEF_HS_START = 304;
    localparam int DEF_HS_WIDTH = 32;
    localparam int DEF_V_TOTAL  = 264;
    localparam int DEF_V_VIS    = 224;
    localparam int DEF_VS_START = 240;
    localparam int DEF_VS_WIDTH = 8;
    localparam int DEF_PIX_LAT  = 2;

    localparam int POUT_R_LSB = 0;
    localparam int POUT_R_MSB = 2;
    localparam int POUT_G_LSB = 3;
    localparam int POUT_G_MSB = 5;
    localparam int POUT_B_LSB = 6;
    localparam int POUT_B_MSB = 7;

    typedef struct packed {
        logic hb;
        logic vb;
        logic hs;
        logic vs;
    } raster_flags_t;

    // Bit replication spreads full-scale codes to 8'hFF and zero to 8'h00.
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

endpackage

// File: rtl/digdug_rgb_expand.sv
// Registered expansion of the 3/3/2 palette pixel to 8/8/8 RGB, forced to
// black while the aligned blank flag is set.
module digdug_rgb_expand
    import digdug_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       blank,
    input  logic [7:0] pix,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    logic [2:0] r3;
    logic [2:0] g3;
    logic [1:0] b2;

    assign r3 = pix[POUT_R_MSB:POUT_R_LSB];
    assign g3 = pix[POUT_G_MSB:POUT_G_LSB];
    assign b2 = pix[POUT_B_MSB:POUT_B_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else if (ce) begin
            if (blank) begin
                r <= '0;
                g <= '0;
                b <= '0;
            end else begin
                r <= expand3(r3);
                g <= expand3(g3);
                b <= expand2(b2);
            end
        end
    end

endmodule

// File: rtl/digdug_hvgen.sv
// Dig Dug video timing: 48 MHz to 6 MHz pixel enable, PH/PV raster counters,
// and a sync/blank delay line aligned with the core's POUT latency.
module digdug_hvgen
    import digdug_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_VIS    = DEF_H_VIS,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_WIDTH = DEF_HS_WIDTH,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_WIDTH = DEF_VS_WIDTH,
    parameter int PIX_LAT  = DEF_PIX_LAT
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic signed [3:0] H_ADJ,
    input  logic        [7:0] POUT,
    output logic              CE_PIX,
    output logic        [8:0] PH,
    output logic        [8:0] PV,
    output logic        [7:0] R,
    output logic        [7:0] G,
    output logic        [7:0] B,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              HBLANK,
    output logic              VBLANK,
    output logic              DE
);

    logic        [2:0] div;
    logic signed [3:0] adj_q;
    logic              line_end;
    logic              frame_end;
    logic signed [9:0] ph_s;
    logic signed [9:0] hs_lo;
    logic signed [9:0] hs_hi;
    raster_flags_t     raw;
    raster_flags_t     tap;
    raster_flags_t     dly [PIX_LAT];

    // CE_PIX is registered one count early so it is high exactly while DIV reads 7.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div    <= '0;
            CE_PIX <= 1'b0;
        end else begin
            div    <= div + 3'd1;
            CE_PIX <= (div == 3'd6);
        end
    end

    assign line_end  = (PH == 9'(H_TOTAL - 1));
    assign frame_end = line_end && (PV == 9'(V_TOTAL - 1));

    // H_ADJ is only taken at the frame wrap so a line never sees a partial shift.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PH    <= '0;
            PV    <= '0;
            adj_q <= '0;
        end else if (CE_PIX) begin
            if (line_end) begin
                PH <= '0;
                if (frame_end) begin
                    PV    <= '0;
                    adj_q <= H_ADJ;
                end else begin
                    PV <= PV + 9'd1;
                end
            end else begin
                PH <= PH + 9'd1;
            end
        end
    end

    always_comb begin
        ph_s   = $signed({1'b0, PH});
        hs_lo  = 10'(HS_START) + {{6{adj_q[3]}}, adj_q};
        hs_hi  = hs_lo + 10'(HS_WIDTH);
        raw.hb = (PH >= 9'(H_VIS));
        raw.vb = (PV >= 9'(V_VIS));
        raw.hs = (ph_s >= hs_lo) && (ph_s < hs_hi);
        raw.vs = (PV >= 9'(VS_START)) && (PV < 9'(VS_START + VS_WIDTH));
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                dly[i] <= '0;
            end
        end else if (CE_PIX) begin
            dly[0] <= raw;
            for (int i = 1; i < PIX_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign tap = dly[PIX_LAT-1];

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HSYNC  <= 1'b0;
            VSYNC  <= 1'b0;
            HBLANK <= 1'b0;
            VBLANK <= 1'b0;
            DE     <= 1'b0;
        end else if (CE_PIX) begin
            HSYNC  <= tap.hs;
            VSYNC  <= tap.vs;
            HBLANK <= tap.hb;
            VBLANK <= tap.vb;
            DE     <= !(tap.hb || tap.vb);
        end
    end

    digdug_rgb_expand u_rgb (
        .clk   (MCLK),
        .rst_n (RESET_N),
        .ce    (CE_PIX),
        .blank (tap.hb | tap.vb),
        .pix   (POUT),
        .r     (R),
        .g     (G),
        .b     (B)
    );

endmodule

// File: tb/tb_digdug_hvgen.sv
// Scoreboard bench for digdug_hvgen on a shrunken raster: the stimulus side
// predicts each pixel's outputs from raster arithmetic, a monitor compares.
module tb_digdug_hvgen;

    localparam int HT    = 56;
    localparam int HV    = 40;
    localparam int HSS   = 44;
    localparam int HSW   = 4;
    localparam int VT    = 20;
    localparam int VV    = 14;
    localparam int VSS   = 16;
    localparam int VSW   = 2;
    localparam int LAT   = 3;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [8:0] ph;
        logic [8:0] pv;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic       de;
    } video_t;

    logic              mclk = 1'b0;
    logic              reset_n = 1'b0;
    logic signed [3:0] h_adj = '0;
    logic        [7:0] pout = '0;
    logic              ce_pix;
    logic        [8:0] ph;
    logic        [8:0] pv;
    logic        [7:0] r;
    logic        [7:0] g;
    logic        [7:0] b;
    logic              hsync;
    logic              vsync;
    logic              hblank;
    logic              vblank;
    logic              de;

    video_t  exp_q[$];
    int      idx_q[$];
    int      errors = 0;
    int      checks = 0;
    int      pix_n = 0;
    int      adj_of_frame [16];
    longint  cyc = 0;
    longint  rel_cyc = 0;
    bit      first_pending = 1'b0;
    bit      done = 1'b0;

    digdug_hvgen #(
        .H_TOTAL  (HT),
        .H_VIS    (HV),
        .HS_START (HSS),
        .HS_WIDTH (HSW),
        .V_TOTAL  (VT),
        .V_VIS    (VV),
        .VS_START (VSS),
        .VS_WIDTH (VSW),
        .PIX_LAT  (LAT)
    ) dut (
        .MCLK    (mclk),
        .RESET_N (reset_n),
        .H_ADJ   (h_adj),
        .POUT    (pout),
        .CE_PIX  (ce_pix),
        .PH      (ph),
        .PV      (pv),
        .R       (r),
        .G       (g),
        .B       (b),
        .HSYNC   (hsync),
        .VSYNC   (vsync),
        .HBLANK  (hblank),
        .VBLANK  (vblank),
        .DE      (de)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: the pixel whose flags reach the outputs on edge n is n-(LAT+1);
    // colour levels are the rounded linear scale of each field.
    function automatic video_t model_pixel(input int n, input logic [7:0] pix);
        video_t v;
        int m, hp, vp, a, rc, gc, bc;
        logic hb, vb, hs, vs;
        v.ph = 9'(n % HT);
        v.pv = 9'((n / HT) % VT);
        m  = n - (LAT + 1);
        hb = 1'b0;
        vb = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        if (m >= 0) begin
            hp = m % HT;
            vp = (m / HT) % VT;
            a  = adj_of_frame[m / FRAME];
            hb = (hp >= HV);
            vb = (vp >= VV);
            hs = (hp >= HSS + a) && (hp < HSS + a + HSW);
            vs = (vp >= VSS) && (vp < VSS + VSW);
        end
        rc = int'(pix) % 8;
        gc = (int'(pix) / 8) % 8;
        bc = int'(pix) / 64;
        v.hs = hs;
        v.vs = vs;
        v.hb = hb;
        v.vb = vb;
        v.de = !(hb || vb);
        if (hb || vb) begin
            v.r = 8'd0;
            v.g = 8'd0;
            v.b = 8'd0;
        end else begin
            v.r = 8'((rc * 255 + 3) / 7);
            v.g = 8'((gc * 255 + 3) / 7);
            v.b = 8'(bc * 85);
        end
        return v;
    endfunction

    task automatic drive_next();
        case ($urandom_range(0, 3))
            0:       pout = 8'hFF;
            1:       pout = 8'h01;
            default: pout = 8'($urandom);
        endcase
        if (pix_n == FRAME / 2)
            h_adj = -4'sd8;
        else if (pix_n == FRAME + FRAME / 2)
            h_adj = 4'sd7;
        else if (pix_n > 2 * FRAME && $urandom_range(0, 63) == 0)
            h_adj = 4'($urandom);
    endtask

    task automatic apply_stimulus(input int n_pixels);
        int target, budget;
        target = pix_n + n_pixels;
        budget = n_pixels * 8 + 64;
        while (pix_n < target && budget > 0) begin
            @(negedge mclk);
            budget--;
            if (ce_pix) begin
                if (((pix_n + 1) % FRAME) == 0 && (pix_n + 1) / FRAME < 16)
                    adj_of_frame[(pix_n + 1) / FRAME] = int'(h_adj);
                exp_q.push_back(model_pixel(pix_n + 1, pout));
                idx_q.push_back(pix_n + 1);
                pix_n++;
                @(posedge mclk);
                #1;
                drive_next();
            end
        end
        if (pix_n < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL pixel_timeout: got %0d pixel enables, required %0d", pix_n, target);
        end
    endtask

    task automatic release_reset();
        @(negedge mclk);
        pout = 8'($urandom);
        for (int i = 0; i < 16; i++) adj_of_frame[i] = 0;
        pix_n         = 0;
        rel_cyc       = cyc;
        first_pending = 1'b1;
        reset_n       = 1'b1;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({ce_pix, ph, pv, r, g, b, hsync, vsync, hblank, vblank, de});
    endfunction

    initial begin : stimulus
        int need;
        reset_n = 1'b0;
        pout    = 8'hFF;
        repeat (5) @(posedge mclk);
        @(negedge mclk);
        check_output("reset_outputs", all_outputs(), 64'd0);
        release_reset();
        apply_stimulus(4 * FRAME);

        // Stop partway along a line and pull reset between clock edges.
        need = (30 - (pix_n % HT) + HT) % HT;
        if (need == 0) need = HT;
        apply_stimulus(need);
        check_output("ph_before_reset", 64'(ph), 64'd30);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        idx_q.delete();
        #1;
        check_output("midline_reset_clear", all_outputs(), 64'd0);
        repeat (3) @(posedge mclk);
        release_reset();
        apply_stimulus(FRAME + 100);

        repeat (2) @(negedge mclk);
        done = 1'b1;
        check_output("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : monitor
        logic   prev_ce;
        longint last_wrap;
        video_t act;
        video_t e;
        int     idx;
        prev_ce   = 1'b0;
        last_wrap = -1;
        forever begin
            @(negedge mclk);
            if (!reset_n || done) begin
                prev_ce   = 1'b0;
                last_wrap = -1;
            end else begin
                if (prev_ce) begin
                    act.ph = ph;
                    act.pv = pv;
                    act.r  = r;
                    act.g  = g;
                    act.b  = b;
                    act.hs = hsync;
                    act.vs = vsync;
                    act.hb = hblank;
                    act.vb = vblank;
                    act.de = de;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_pixel: got pixel enable at ph=%0d pv=%0d, required none", ph, pv);
                    end else begin
                        e   = exp_q.pop_front();
                        idx = idx_q.pop_front();
                        check_output($sformatf("pixel_%0d", idx), 64'(act), 64'(e));
                        if (first_pending) begin
                            first_pending = 1'b0;
                            check_output("first_ce_latency", 64'(cyc - rel_cyc), 64'd8);
                        end
                        if (act.ph == 9'd0 && act.pv == 9'd0) begin
                            if (last_wrap >= 0)
                                check_output("frame_period", 64'(cyc - last_wrap), 64'(FRAME * 8));
                            last_wrap = cyc;
                        end
                    end
                end
                prev_ce = ce_pix;
            end
        end
    end

endmodule
